// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus LED register and optional timer (enabled by defining DMEM_TIMER_EN)
module dmem_mmio #(
  parameter int RAM_AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  LED,
  output logic        TimerIrq
);
  localparam logic [29:0] LED_A = 30'h40, CNT_A = 30'h41, CMP_A = 30'h42, CTRL_A = 30'h43;
  logic [31:0] mem_q [2**RAM_AW];
  logic [29:0] wa;
  logic        ram_hit, unused_lsb;
  logic [7:0]  led_q, led_d;
  logic [31:0] tmr_rd;
  assign wa         = Addr[31:2];
  assign unused_lsb = ^Addr[1:0];
  assign ram_hit    = Addr[31:RAM_AW+2] == '0;
  assign ReadData   = ram_hit ? mem_q[Addr[RAM_AW+1:2]] : wa == LED_A ? {24'b0, led_q} : tmr_rd;
  assign LED        = led_q;
  // RAM store, deliberately untouched by reset so program data survives it
  always_ff @(posedge clk)
    if (MemWrite && ram_hit) mem_q[Addr[RAM_AW+1:2]] <= WriteData;
  // LED next state
  always_comb led_d = MemWrite && wa == LED_A ? WriteData[7:0] : led_q;
  // LED register
  always_ff @(posedge clk)
    led_q <= reset ? 8'h00 : led_d;
`ifdef DMEM_TIMER_EN
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        en_q, en_d, arld_q, arld_d, flag_q, flag_d, match, wr_ctrl;
  assign wr_ctrl  = MemWrite && wa == CTRL_A;
  assign tmr_rd   = wa == CNT_A ? cnt_q : wa == CMP_A ? cmp_q :
                    wa == CTRL_A ? {29'b0, flag_q, arld_q, en_q} : 32'h0;
  assign TimerIrq = flag_q;
  // timer next state: CPU write beats reload/increment, hardware set beats W1C
  always_comb begin
    match  = en_q && cnt_q == cmp_q;
    cnt_d  = MemWrite && wa == CNT_A ? WriteData : !en_q ? cnt_q : match && arld_q ? 32'h0 : cnt_q + 32'h1;
    cmp_d  = MemWrite && wa == CMP_A ? WriteData : cmp_q;
    en_d   = wr_ctrl ? WriteData[0] : en_q;
    arld_d = wr_ctrl ? WriteData[1] : arld_q;
    flag_d = match || (flag_q && !(wr_ctrl && WriteData[2]));
  end
  // timer registers
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q  <= 32'h0;
      cmp_q  <= 32'hFFFF_FFFF;
      en_q   <= 1'b0;
      arld_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      en_q   <= en_d;
      arld_q <= arld_d;
      flag_q <= flag_d;
    end
`else
  assign tmr_rd   = 32'h0;
  assign TimerIrq = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed stimulus against a behavioural memory-map model, checked every cycle
module tb_dmem_mmio;
  logic        clk = 1'b0, reset, MemWrite;
  logic [31:0] Addr, WriteData, ReadData;
  logic [7:0]  LED;
  logic        TimerIrq;
  int          total = 0, bad = 0;
  logic [31:0] m_mem [64];
  bit          m_ok [64];
  logic [7:0]  m_led;
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_arld, m_flag;
  bit          started = 0;

  dmem_mmio #(.RAM_AW(6)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .LED(LED), .TimerIrq(TimerIrq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w < 32'h100) return m_mem[w[7:2]];
    if (w == 32'h100) return {24'h0, m_led};
`ifdef DMEM_TIMER_EN
    if (w == 32'h104) return m_cnt;
    if (w == 32'h108) return m_cmp;
    if (w == 32'h10C) return {29'h0, m_flag, m_arld, m_en};
`endif
    return 32'h0;
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    return a >= 32'h100 || m_ok[a[7:2]];
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
`ifdef DMEM_TIMER_EN
    logic [31:0] nc;
    logic        hit, nf;
`endif
    w = Addr & ~32'h3;
    if (MemWrite && w < 32'h100) begin
      m_mem[w[7:2]] <= WriteData;
      m_ok[w[7:2]]  <= 1'b1;
    end
    if (reset) begin
      m_led <= 8'h0; m_cnt <= 32'h0; m_cmp <= 32'hFFFF_FFFF;
      m_en <= 1'b0; m_arld <= 1'b0; m_flag <= 1'b0; started <= 1'b1;
    end else begin
      if (MemWrite && w == 32'h100) m_led <= WriteData[7:0];
`ifdef DMEM_TIMER_EN
      hit = m_en && m_cnt == m_cmp;
      nc  = !m_en ? m_cnt : (hit && m_arld) ? 32'h0 : m_cnt + 32'h1;
      nf  = hit || (m_flag && !(MemWrite && w == 32'h10C && WriteData[2]));
      if (MemWrite && w == 32'h104) nc = WriteData;
      if (MemWrite && w == 32'h108) m_cmp <= WriteData;
      if (MemWrite && w == 32'h10C) begin
        m_en   <= WriteData[0];
        m_arld <= WriteData[1];
      end
      m_cnt  <= nc;
      m_flag <= nf;
`endif
    end
  end

  always @(negedge clk)
    if (started) begin
      if (m_known(Addr)) chk("rdata", ReadData, m_read(Addr));
      chk("led", {24'h0, LED}, {24'h0, m_led});
      chk("irq", {31'h0, TimerIrq}, {31'h0, m_flag});
    end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    MemWrite = 1'b0; Addr = a;
    #1 chk(n, ReadData, e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_led", {24'h0, LED}, 32'h0);
    chk("rst_irq", {31'h0, TimerIrq}, 32'h0);
    wr(32'h0C, 32'h1234_5678);
    wr(32'h08, 32'hDEAD_BEEF);
    rd(32'h08, 32'hDEAD_BEEF, "ram08");
    rd(32'h0C, 32'h1234_5678, "ram0c");
    MemWrite = 1'b1; Addr = 32'h08; WriteData = 32'h55;
    #1 chk("old_rd", ReadData, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rd(32'h08, 32'h55, "new08");
    wr(32'h08, 32'hDEAD_BEEF);
    rd(32'h0B, 32'hDEAD_BEEF, "lsb_ign");
    wr(32'hFC, 32'hCAFE_F00D);
    rd(32'hFC, 32'hCAFE_F00D, "ram_top");
    wr(32'h100, 32'h1A5);
    chk("led_a5", {24'h0, LED}, 32'hA5);
    rd(32'h100, 32'hA5, "led_rd");
    wr(32'h200, 32'hFFFF_FFFF);
    rd(32'h200, 32'h0, "unmap_rd");
    chk("led_keep", {24'h0, LED}, 32'hA5);
    wr(32'h1008, 32'h11);
    rd(32'h08, 32'hDEAD_BEEF, "no_alias");
`ifndef DMEM_TIMER_EN
    rd(32'h104, 32'h0, "notmr_cnt");
    wr(32'h10C, 32'h7);
    rd(32'h10C, 32'h0, "notmr_ctrl");
    chk("notmr_irq", {31'h0, TimerIrq}, 32'h0);
`else
    wr(32'h108, 32'h5);
    wr(32'h10C, 32'h3);
    for (int i = 0; i <= 5; i++) rd(32'h104, 32'(i), "cnt_up");
    chk("irq_set", {31'h0, TimerIrq}, 32'h1);
    rd(32'h104, 32'h0, "cnt_rld");
    rd(32'h10C, 32'h7, "ctrl_rd");
    wr(32'h10C, 32'h4);
    chk("irq_clr", {31'h0, TimerIrq}, 32'h0);
    rd(32'h104, 32'h3, "cnt_stop");
    rd(32'h104, 32'h3, "cnt_hold");
    wr(32'h104, 32'hFFFF_FFFE);
    wr(32'h108, 32'h10);
    wr(32'h10C, 32'h1);
    rd(32'h104, 32'hFFFF_FFFE, "cnt_fe");
    rd(32'h104, 32'hFFFF_FFFF, "cnt_ff");
    rd(32'h104, 32'h0, "cnt_wrap");
    for (int i = 1; i <= 15; i++) rd(32'h104, 32'(i), "cnt_run");
    wr(32'h10C, 32'h5);
    chk("set_wins", {31'h0, TimerIrq}, 32'h1);
    rd(32'h10C, 32'h5, "ctrl_set");
    wr(32'h104, 32'h100);
    rd(32'h104, 32'h100, "cpu_wins");
    wr(32'h10C, 32'h4);
    chk("irq_off", {31'h0, TimerIrq}, 32'h0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_led2", {24'h0, LED}, 32'h0);
    rd(32'h08, 32'hDEAD_BEEF, "ram_keep");
    rd(32'h100, 32'h0, "led_rd0");
    repeat (2) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
